shift_ctrl: RTL and testbench

SHIFT_CTRL -- requirements
Module: shift_ctrl

---
 rtl/shift_ctrl.sv | 117 +++++++++++
 tb/tb_shift_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/shift_ctrl.sv
// Serializes a parallel word into an external shift register and recaptures it from the far end.
// Optional SHIFT_CTRL_LOOPBACK_CHECK_EN adds a mismatch flag comparing the recaptured word to the sent word.
module shift_ctrl #(
   parameter int WORD  = 8,
   parameter int DEPTH = 4,
   parameter int LAT   = DEPTH + 1
) (
   input  logic            clk,
   input  logic            clear_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [WORD-1:0] in_data,
   output logic            sr_clear,
   output logic            sr_si,
   input  logic            sr_so,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [WORD-1:0] out_data,
   output logic            busy
`ifdef SHIFT_CTRL_LOOPBACK_CHECK_EN
   ,
   output logic            mismatch
`endif
);

   localparam int RUNLEN = WORD + LAT;
   localparam int CW     = $clog2(RUNLEN + 1);
   localparam int IW     = (WORD > 1) ? $clog2(WORD) : 1;
   localparam logic [CW-1:0] WORD_C = CW'(WORD);
   localparam logic [CW-1:0] WM1_C  = CW'(WORD - 1);
   localparam logic [CW-1:0] LAT_C  = CW'(LAT);
   localparam logic [CW-1:0] LAST_C = CW'(RUNLEN - 1);

   typedef enum logic [1:0] {IDLE, CLR, RUN, HOLD} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [WORD-1:0] tx_q, tx_d;
   logic [WORD-1:0] rx_q, rx_d;
   logic [CW-1:0]   bit_idx;

   // Transmit bit index counts down from the MSB as cnt advances.
   assign bit_idx = WM1_C - cnt_q;

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      in_ready  = 1'b0;
      sr_clear  = 1'b0;
      sr_si     = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               tx_d    = in_data;
               state_d = CLR;
            end
         end
         CLR: begin
            sr_clear = 1'b1;
            cnt_d    = '0;
            state_d  = RUN;
         end
         RUN: begin
            if (cnt_q < WORD_C) sr_si = tx_q[bit_idx[IW-1:0]];
            // Bits driven at cnt-LAT emerge now; the first LAT cycles only fill the register.
            if (cnt_q >= LAT_C) rx_d = {rx_q[WORD-2:0], sr_so};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_C) state_d = HOLD;
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign out_data = rx_q;

`ifdef SHIFT_CTRL_LOOPBACK_CHECK_EN
   logic mismatch_q;

   // Compare against rx_d so the final sample taken on the entering edge is included.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         mismatch_q <= 1'b0;
      end else if (state_q == RUN && state_d == HOLD) begin
         mismatch_q <= (rx_d != tx_q);
      end else if (state_q == HOLD && state_d == IDLE) begin
         mismatch_q <= 1'b0;
      end
   end

   assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_shift_ctrl.sv
// Bench for shift_ctrl: directed and random words looped through a modelled LAT-cycle shift register.
module tb_shift_ctrl;
   localparam int WORD  = 8;
   localparam int DEPTH = 4;
   localparam int LAT   = DEPTH + 1;

   logic            clk = 1'b0;
   logic            clear_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [WORD-1:0] in_data = '0;
   logic            sr_clear;
   logic            sr_si;
   logic            sr_so;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [WORD-1:0] out_data;
   logic            busy;
`ifdef SHIFT_CTRL_LOOPBACK_CHECK_EN
   logic            mismatch;
`endif

   logic [LAT-1:0]  srpipe = '0;
   logic            force0 = 1'b0;
   int              total = 0;
   int              bad = 0;

   shift_ctrl #(.WORD(WORD), .DEPTH(DEPTH), .LAT(LAT)) dut (
      .clk(clk), .clear_n(clear_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .sr_clear(sr_clear), .sr_si(sr_si), .sr_so(sr_so),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy)
`ifdef SHIFT_CTRL_LOOPBACK_CHECK_EN
      , .mismatch(mismatch)
`endif
   );

   always #5 clk = ~clk;

   // Attached serial register: a bit on sr_si shows up on sr_so LAT cycles later.
   always @(posedge clk) begin
      if (sr_clear) srpipe <= '0;
      else          srpipe <= {srpipe[LAT-2:0], sr_si};
   end
   assign sr_so = force0 ? 1'b0 : srpipe[LAT-1];

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge after HOLD is released.
   task automatic do_txn(input logic [WORD-1:0] w, input logic [WORD-1:0] exp,
                         input int hold, input logic exp_mm);
      int  lat;
      bit  seen;
      logic exp_si;
      in_valid  = 1'b1;
      in_data   = w;
      out_ready = 1'b0;
      chk("idle_in_ready", in_ready, 1);
      chk("idle_busy", busy, 0);
      lat  = -1;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1;
            lat  = i;
         end else begin
            exp_si = (i >= 1 && i <= WORD) ? w[WORD-i] : 1'b0;
            chk("sr_clear", sr_clear, (i == 0) ? 1 : 0);
            chk("sr_si", sr_si, exp_si);
            chk("busy_tx", busy, 1);
            chk("in_ready_tx", in_ready, 0);
            in_data = WORD'($urandom);
         end
      end
      chk("latency", lat, 1 + WORD + LAT);
      chk("out_data", out_data, exp);
      chk("hold_sr_si", sr_si, 0);
`ifdef SHIFT_CTRL_LOOPBACK_CHECK_EN
      chk("mismatch", mismatch, exp_mm);
`endif
      for (int h = 0; h < hold; h++) begin
         in_data = WORD'($urandom);
         @(negedge clk);
         chk("hold_valid", out_valid, 1);
         chk("hold_data", out_data, exp);
         chk("hold_in_ready", in_ready, 0);
         chk("hold_busy", busy, 1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("post_valid", out_valid, 0);
      chk("post_in_ready", in_ready, 1);
      chk("post_busy", busy, 0);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [WORD-1:0] w;
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_sr_clear", sr_clear, 0);
      chk("rst_sr_si", sr_si, 0);
      @(negedge clk);
      clear_n = 1'b1;
      do_txn(8'hA5, 8'hA5, 0, 1'b0);
      in_valid = 1'b0;
      @(negedge clk);

      do_txn(8'h00, 8'h00, 0, 1'b0);
      do_txn(8'hFF, 8'hFF, 0, 1'b0);
      do_txn(8'h3C, 8'h3C, 0, 1'b0);
      do_txn(8'h96, 8'h96, 10, 1'b0);
      in_valid = 1'b0;
      @(negedge clk);

      // Abort mid-RUN at cnt=6.
      in_valid = 1'b1;
      in_data  = 8'h5A;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      clear_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_in_ready", in_ready, 1);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_out_data", out_data, 0);
      chk("abort_sr_si", sr_si, 0);
      @(negedge clk);
      clear_n = 1'b1;
      do_txn(8'h81, 8'h81, 0, 1'b0);
      in_valid = 1'b0;
      @(negedge clk);

`ifdef SHIFT_CTRL_LOOPBACK_CHECK_EN
      force0 = 1'b1;
      do_txn(8'h01, 8'h00, 0, 1'b1);
      do_txn(8'h00, 8'h00, 0, 1'b0);
      force0 = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
`endif

      for (int n = 0; n < 12; n++) begin
         w = WORD'($urandom);
         do_txn(w, w, $urandom_range(0, 3), 1'b0);
         if ($urandom_range(0, 1) == 1) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) begin
               @(negedge clk);
               chk("gap_in_ready", in_ready, 1);
            end
         end
      end
      in_valid = 1'b0;
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
